// File: rtl/bcd_count_ctrl.sv
// Command-driven sequencer for a cascaded BCD up/down counter with a
// programmable terminal value, START/STOP/LOAD/CLEAR over valid/ready.
module bcd_count_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic [4*DIGITS-1:0]   target,
    input  logic                  dir,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  at_target,
    output logic                  done,
    output logic                  err
);

    localparam int W = 4 * DIGITS;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_LOAD  = 2'd2;
    localparam logic [1:0] CMD_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   tgt_q, tgt_d;
    logic           dir_q, dir_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic           running_q, running_d;
    logic           at_target_q, at_target_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           accept;
    logic [W-1:0]   step;

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Full-width ripple: each digit only moves while a carry/borrow is still pending.
    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (up) begin
                    if (v[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign accept = cmd_valid && cmd_ready_q;
    assign step   = bcd_step(count_q, dir_q);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        tgt_d       = tgt_q;
        dir_d       = dir_q;
        cmd_ready_d = !accept;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (accept) begin
            // An accepted command always pre-empts a same-cycle tick.
            case (cmd)
                CMD_START: begin
                    if (state_q == S_IDLE || state_q == S_PAUSE) begin
                        if (bcd_valid(target)) begin
                            tgt_d   = target;
                            dir_d   = dir;
                            state_d = S_RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CMD_STOP: begin
                    if (state_q == S_RUN) state_d = S_PAUSE;
                end
                CMD_LOAD: begin
                    if (bcd_valid(load_value)) begin
                        count_d = load_value;
                        state_d = S_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    count_d = '0;
                    state_d = S_IDLE;
                end
            endcase
        end else if (tick && state_q == S_RUN) begin
            count_d = step;
            if (step == tgt_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end

        running_d   = (state_d == S_RUN);
        at_target_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            tgt_q       <= '0;
            dir_q       <= 1'b1;
            cmd_ready_q <= 1'b1;
            running_q   <= 1'b0;
            at_target_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tgt_q       <= tgt_d;
            dir_q       <= dir_d;
            cmd_ready_q <= cmd_ready_d;
            running_q   <= running_d;
            at_target_q <= at_target_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign count     = count_q;
    assign running   = running_q;
    assign at_target = at_target_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: directed scenarios followed by random traffic,
// every cycle compared against an integer-valued reference model.
module tb_bcd_count_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int M      = 10000;

    localparam int MS_IDLE  = 0;
    localparam int MS_RUN   = 1;
    localparam int MS_PAUSE = 2;
    localparam int MS_DONE  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd;
    logic [W-1:0]   load_value;
    logic [W-1:0]   target;
    logic           dir;
    logic           tick;
    logic [W-1:0]   count;
    logic           running;
    logic           at_target;
    logic           done;
    logic           err;

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt   = 0;
    int m_tgt   = 0;
    bit m_up    = 1'b1;
    int m_state = MS_IDLE;
    bit m_ready = 1'b1;
    bit m_done  = 1'b0;
    bit m_err   = 1'b0;

    always #5 clk = ~clk;

    bcd_count_ctrl #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .load_value (load_value),
        .target     (target),
        .dir        (dir),
        .tick       (tick),
        .count      (count),
        .running    (running),
        .at_target  (at_target),
        .done       (done),
        .err        (err)
    );

    function automatic bit is_bcd(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int to_int(input logic [W-1:0] v);
        int n;
        n = 0;
        for (int i = DIGITS - 1; i >= 0; i--) n = n * 10 + int'(v[4*i +: 4]);
        return n;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r;
        int           k;
        r = '0;
        k = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(k % 10);
            k = k / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference behaviour at one clock edge, from the inputs present at that edge.
    task automatic model_edge();
        bit acc;
        if (!rst) begin
            m_cnt = 0; m_tgt = 0; m_up = 1'b1; m_state = MS_IDLE;
            m_ready = 1'b1; m_done = 1'b0; m_err = 1'b0;
            return;
        end
        acc     = cmd_valid && m_ready;
        m_ready = !acc;
        m_done  = 1'b0;
        m_err   = 1'b0;
        if (acc) begin
            case (cmd)
                2'd0: if (m_state == MS_IDLE || m_state == MS_PAUSE) begin
                    if (is_bcd(target)) begin
                        m_tgt = to_int(target); m_up = dir; m_state = MS_RUN;
                    end else m_err = 1'b1;
                end
                2'd1: if (m_state == MS_RUN) m_state = MS_PAUSE;
                2'd2: if (is_bcd(load_value)) begin
                    m_cnt = to_int(load_value); m_state = MS_IDLE;
                end else m_err = 1'b1;
                default: begin m_cnt = 0; m_state = MS_IDLE; end
            endcase
        end else if (tick && m_state == MS_RUN) begin
            m_cnt = m_up ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
            if (m_cnt == m_tgt) begin
                m_state = MS_DONE;
                m_done  = 1'b1;
            end
        end
    endtask

    task automatic cyc(input bit v, input logic [1:0] c, input logic [W-1:0] lv,
                       input logic [W-1:0] tg, input bit d, input bit t, input bit r);
        cmd_valid = v; cmd = c; load_value = lv; target = tg; dir = d; tick = t; rst = r;
        @(posedge clk);
        model_edge();
        #1;
        check("count",     32'(count),     32'(to_bcd(m_cnt)));
        check("running",   32'(running),   32'(m_state == MS_RUN));
        check("at_target", 32'(at_target), 32'(m_state == MS_DONE));
        check("done",      32'(done),      32'(m_done));
        check("err",       32'(err),       32'(m_err));
        check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
    endtask

    task automatic idle(input int n, input bit t);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, '0, '0, 1'b0, t, 1'b1);
    endtask

    task automatic command(input logic [1:0] c, input logic [W-1:0] lv,
                           input logic [W-1:0] tg, input bit d, input bit t);
        cyc(1'b1, c, lv, tg, d, t, 1'b1);
        cyc(1'b0, 2'd0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int k;
        bit v, d, t, r;
        logic [1:0] c;
        logic [W-1:0] lv, tg;

        cyc(1'b1, 2'd2, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 2'd0, 16'h0000, 16'h0005, 1'b1, 1'b1, 1'b0);

        // Up-count across a multi-digit carry into the target.
        command(2'd2, 16'h0998, 16'h0000, 1'b0, 1'b0);
        command(2'd0, 16'h0000, 16'h1000, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Down-count through the all-zero wrap.
        command(2'd2, 16'h0000, 16'h0000, 1'b0, 1'b0);
        command(2'd0, 16'h0000, 16'h9998, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Invalid BCD operands are rejected.
        command(2'd2, 16'h12A4, 16'h0000, 1'b0, 1'b0);
        command(2'd0, 16'h0000, 16'h00F0, 1'b1, 1'b0);

        // STOP with a simultaneous tick, then resume.
        command(2'd2, 16'h0010, 16'h0000, 1'b0, 1'b0);
        command(2'd0, 16'h0000, 16'h0050, 1'b1, 1'b0);
        idle(2, 1'b1);
        command(2'd1, 16'h0000, 16'h0000, 1'b0, 1'b1);
        idle(2, 1'b1);
        command(2'd0, 16'h0000, 16'h0050, 1'b1, 1'b0);
        idle(1, 1'b1);

        // Pin changes mid-RUN must not disturb the latched direction/target.
        cyc(1'b0, 2'd0, '0, 16'h0014, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 2'd0, '0, 16'h0013, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Reset in the middle of RUN, then ticks without a START.
        cyc(1'b1, 2'd0, '0, 16'h0200, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        command(2'd0, 16'h0000, 16'h0003, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Starting with count already equal to target runs a full wrap.
        command(2'd2, 16'h9990, 16'h0000, 1'b0, 1'b0);
        command(2'd0, 16'h0000, 16'h9990, 1'b1, 1'b0);
        idle(12, 1'b1);
        command(2'd3, 16'h0000, 16'h0000, 1'b0, 1'b0);

        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 199) != 0);
            v = ($urandom_range(0, 4) == 0);
            k = $urandom_range(0, 9);
            c = (k < 4) ? 2'd0 : (k < 7) ? 2'd1 : (k < 9) ? 2'd2 : 2'd3;
            lv = ($urandom_range(0, 7) == 0) ? W'($urandom) : to_bcd($urandom_range(0, M - 1));
            d = 1'($urandom_range(0, 1));
            k = $urandom_range(1, 30);
            tg = ($urandom_range(0, 7) == 0) ? W'($urandom)
                                               : to_bcd((m_cnt + (d ? k : M - k)) % M);
            t = ($urandom_range(0, 3) != 0);
            cyc(v, c, lv, tg, d, t, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
